// File: rtl/rx_link_ctrl_pkg.sv
// ============================================================================
// Module  : rx_link_ctrl_pkg
// Brief   : State encodings, fault codes and helpers shared by rx_link_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rx_link_ctrl_pkg;

  localparam logic [1:0] RX_LINK_ST_HOLDOFF = 2'd0;
  localparam logic [1:0] RX_LINK_ST_UP      = 2'd1;
  localparam logic [1:0] RX_LINK_ST_DRAIN   = 2'd2;
  localparam logic [1:0] RX_LINK_ST_FAULT   = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLDOFF = RX_LINK_ST_HOLDOFF,
    ST_UP      = RX_LINK_ST_UP,
    ST_DRAIN   = RX_LINK_ST_DRAIN,
    ST_FAULT   = RX_LINK_ST_FAULT
  } rx_link_st_e;

  localparam logic [1:0] TX_FAULT_RESP_NORMAL = 2'b00;
  localparam logic [1:0] TX_FAULT_RESP_REMOTE = 2'b01;
  localparam logic [1:0] TX_FAULT_RESP_IDLE   = 2'b10;

  localparam logic [1:0] LINK_FAULT_OK     = 2'b00;
  localparam logic [1:0] LINK_FAULT_LOCAL  = 2'b01;
  localparam logic [1:0] LINK_FAULT_REMOTE = 2'b10;

  localparam logic [15:0] SAT_CNT16_MAX = 16'hFFFF;

  // Local fault answers with remote-fault signalling and wins over remote.
  function automatic logic [1:0] fault_resp(input logic loc_flt, input logic rem_flt);
    if (loc_flt)      return TX_FAULT_RESP_REMOTE;
    else if (rem_flt) return TX_FAULT_RESP_IDLE;
    else              return TX_FAULT_RESP_NORMAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_cnt16.sv
// ============================================================================
// Module  : sat_cnt16
// Brief   : 16-bit saturating event counter; clear and increment together give 1.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_cnt16
  import rx_link_ctrl_pkg::*;
(
  input  logic        clk_xgmii_rx,
  input  logic        reset_xgmii_rx_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
    if (!reset_xgmii_rx_n) begin
      r_cnt <= 16'd0;
    end else if (clr) begin
      r_cnt <= {15'd0, inc};
    end else if (inc && (r_cnt != SAT_CNT16_MAX)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/rx_link_ctrl.sv
// ============================================================================
// Module  : rx_link_ctrl
// Brief   : XGMII RX link-state controller (holdoff / up / drain / fault).
//           Optional drain state enabled by macro RX_LINK_CTRL_DRAIN_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_link_ctrl
  import rx_link_ctrl_pkg::*;
#(
  parameter int HOLDOFF_CYC = 16,
  parameter int DRAIN_MAX   = 1250
) (
  input  logic        clk_xgmii_rx,
  input  logic        reset_xgmii_rx_n,
  input  logic        status_local_fault_crx,
  input  logic        status_remote_fault_crx,
  input  logic        rx_frame_active,
  input  logic        stat_clr,
  output logic        rx_enable,
  output logic        rx_abort,
  output logic [1:0]  tx_fault_resp,
  output logic        link_up,
  output logic        int_link_change,
  output logic [1:0]  fault_sticky,
  output logic [15:0] link_drop_cnt
);

  localparam logic [15:0] c_holdoff_last = 16'(HOLDOFF_CYC - 1);
`ifdef RX_LINK_CTRL_DRAIN_EN
  localparam logic [15:0] c_drain_last   = 16'(DRAIN_MAX - 1);
`endif

  rx_link_st_e r_state;
  logic [15:0] r_tmr;
  logic        r_abort_req;
  logic        w_flt;
  logic        w_up_exit;
  logic [1:0]  w_flt_vec;

  assign w_flt     = status_local_fault_crx | status_remote_fault_crx;
  assign w_up_exit = (r_state == ST_UP) && w_flt;
  assign w_flt_vec = (status_local_fault_crx  ? LINK_FAULT_LOCAL  : LINK_FAULT_OK) |
                     (status_remote_fault_crx ? LINK_FAULT_REMOTE : LINK_FAULT_OK);

  // r_abort_req is staged one cycle so rx_abort lands on the first rx_enable=0 cycle.
  always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
    if (!reset_xgmii_rx_n) begin
      r_state         <= ST_HOLDOFF;
      r_tmr           <= 16'd0;
      r_abort_req     <= 1'b0;
      rx_enable       <= 1'b0;
      rx_abort        <= 1'b0;
      tx_fault_resp   <= TX_FAULT_RESP_NORMAL;
      link_up         <= 1'b0;
      int_link_change <= 1'b0;
      fault_sticky    <= 2'b00;
    end else begin
      r_abort_req <= 1'b0;
      case (r_state)
        ST_HOLDOFF: begin
          if (w_flt) begin
            r_state <= ST_FAULT;
          end else if ((r_tmr == c_holdoff_last) && !rx_frame_active) begin
            r_state <= ST_UP;
          end else if (r_tmr != c_holdoff_last) begin
            r_tmr <= r_tmr + 16'd1;
          end
        end
        ST_UP: begin
          if (w_flt) begin
`ifdef RX_LINK_CTRL_DRAIN_EN
            if (rx_frame_active) begin
              r_state <= ST_DRAIN;
              r_tmr   <= 16'd0;
            end else begin
              r_state <= ST_FAULT;
            end
`else
            r_state     <= ST_FAULT;
            r_abort_req <= rx_frame_active;
`endif
          end
        end
`ifdef RX_LINK_CTRL_DRAIN_EN
        ST_DRAIN: begin
          if (!rx_frame_active) begin
            r_state <= ST_FAULT;
          end else if (r_tmr == c_drain_last) begin
            r_state     <= ST_FAULT;
            r_abort_req <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 16'd1;
          end
        end
`endif
        ST_FAULT: begin
          if (!w_flt) begin
            r_state <= ST_HOLDOFF;
            r_tmr   <= 16'd0;
          end
        end
        default: r_state <= ST_HOLDOFF;
      endcase

      rx_enable       <= (r_state == ST_UP) || (r_state == ST_DRAIN);
      link_up         <= (r_state == ST_UP);
      int_link_change <= (r_state == ST_UP) != link_up;
      rx_abort        <= r_abort_req;
      tx_fault_resp   <= fault_resp(status_local_fault_crx, status_remote_fault_crx);
      fault_sticky    <= w_flt_vec | (stat_clr ? 2'b00 : fault_sticky);
    end
  end

  sat_cnt16 u_drop_cnt (
    .clk_xgmii_rx     (clk_xgmii_rx),
    .reset_xgmii_rx_n (reset_xgmii_rx_n),
    .clr              (stat_clr),
    .inc              (w_up_exit),
    .cnt              (link_drop_cnt)
  );

endmodule

`default_nettype wire

// File: doc/rx_link_ctrl.md
# rx_link_ctrl

Link-state controller on the XGMII receive side. It consumes the registered local/remote fault status from the fault state machine and sequences the RX datapath: it gates frame acceptance, drains or aborts an in-flight frame when a fault appears, and holds the link down for a programmable clean interval before re-enabling. It also produces the RS fault-response request for the transmit side, plus sticky status, interrupt pulses and a link-drop counter for the register block.

## Interface
- HOLDOFF_CYC, 16: clean cycles required in ST_HOLDOFF before the link is declared up; legal range 1..65535.
- DRAIN_MAX, 1250: maximum cycles spent in ST_DRAIN before a forced abort; legal range 1..65535.
- clk_xgmii_rx  in  1  XGMII RX clock; all logic is on its rising edge.
- reset_xgmii_rx_n  in  1  reset; asynchronous, active-low.
- status_local_fault_crx  in  1  registered local-fault status.
- status_remote_fault_crx  in  1  registered remote-fault status.
- rx_frame_active  in  1  high from frame start through the terminate cycle.
- stat_clr  in  1  single-cycle pulse; clears fault_sticky and link_drop_cnt.
- rx_enable  out  1  RX datapath may accept frames.
- rx_abort  out  1  single-cycle pulse; the RX datapath must discard the current frame.
- tx_fault_resp  out  2  fault response for TX: 2'b00 normal, 2'b01 send remote fault, 2'b10 send idle.
- link_up  out  1  high while in ST_UP.
- int_link_change  out  1  single-cycle pulse whenever link_up toggles.
- fault_sticky  out  2  bit0 latches local fault, bit1 latches remote fault.
- link_drop_cnt  out  16  saturating count of exits from ST_UP.

## Operation
- The FSM has four states: ST_HOLDOFF, ST_UP, ST_DRAIN, ST_FAULT. A single 16-bit timer `tmr` is shared between ST_HOLDOFF and ST_DRAIN.
- `flt` = status_local_fault_crx | status_remote_fault_crx.
- **ST_HOLDOFF** (reset state, tmr=0)
  - If flt: go to ST_FAULT.
  - Else if tmr == HOLDOFF_CYC-1 and !rx_frame_active: go to ST_UP.
  - Else: tmr increments, saturating at HOLDOFF_CYC-1. The up-transition therefore waits for a frame boundary.
- **ST_UP**
  - If flt and rx_frame_active: go to ST_DRAIN with tmr=0.
  - If flt and !rx_frame_active: go to ST_FAULT.
- **ST_DRAIN**
  - If !rx_frame_active: go to ST_FAULT.
  - Else if tmr == DRAIN_MAX-1: go to ST_FAULT and pulse rx_abort.
  - Else: tmr increments.
  - Fault clearing during drain does not return the FSM to ST_UP.
- **ST_FAULT**
  - If !flt: go to ST_HOLDOFF with tmr=0.
- Any flt reassertion in ST_HOLDOFF restarts the sequence through ST_FAULT.
- rx_enable = 1 in ST_UP and ST_DRAIN, 0 otherwise.
- link_up = 1 in ST_UP only.
- tx_fault_resp depends only on the status inputs, not on the FSM state:
  - local fault: 2'b01 (local has priority when both are set);
  - remote fault only: 2'b10;
  - neither: 2'b00.
- fault_sticky[n] is set when the corresponding status is high and cleared by stat_clr. If set and clear occur in the same cycle, set wins.
- link_drop_cnt increments on every ST_UP exit and saturates at 16'hFFFF. stat_clr zeroes it; if clear and increment coincide, the result is 1.

## Timing
- All outputs are registered and reflect state/inputs with 1-cycle latency. Example: status rises at edge N, and tx_fault_resp changes at edge N+1.
- rx_enable falls 1 cycle after the FSM enters ST_FAULT.
- A fault-free link-up takes HOLDOFF_CYC cycles after entering ST_HOLDOFF, plus the output register cycle.
- rx_abort is exactly 1 cycle wide and coincides with the first cycle of rx_enable = 0.
- int_link_change is exactly 1 cycle wide, aligned with the link_up edge.
- Reset values: rx_enable=0, rx_abort=0, tx_fault_resp=2'b00, link_up=0, int_link_change=0, fault_sticky=2'b00, link_drop_cnt=0, state=ST_HOLDOFF, tmr=0.
- Reset asserted mid-operation returns all outputs and the FSM to their reset values immediately. No rx_abort is emitted.

## Configuration
- **RX_LINK_CTRL_DRAIN_EN**
  - Defined: ST_DRAIN behaves as described above.
  - Undefined: ST_DRAIN and the DRAIN_MAX logic are removed. A fault in ST_UP goes straight to ST_FAULT; if rx_frame_active is high in that cycle, rx_abort pulses with the rx_enable fall.

## Structure
- defines.v gains RX_LINK_ST_* state encodings (2 bits) and TX_FAULT_RESP_NORMAL/REMOTE/IDLE codes. The block also reuses the existing LINK_FAULT_* codes.
- The block is a single module. The saturating 16-bit link_drop_cnt with clear/increment priority is factored into a sub-module named sat_cnt16.

## Test plan
- **Clean bring-up:** reset release with no faults and rx_frame_active=0, HOLDOFF_CYC=16 -> link_up and rx_enable rise on the 17th edge after reset release, with a 1-cycle int_link_change.
- **Local fault while idle:** in ST_UP, assert local status for 10 cycles -> tx_fault_resp=01, rx_enable=0, fault_sticky=01, link_drop_cnt=1. After the clear, link re-up follows 16+1 cycles.
- **Drain completes:** remote fault with rx_frame_active high for 40 more cycles -> rx_enable stays 1 for 40 cycles then falls, no rx_abort, tx_fault_resp=10.
- **Drain timeout:** DRAIN_MAX=8, frame held active -> rx_abort pulses 8 cycles after fault entry. Rerun with the macro undefined -> rx_abort pulses on the first fault cycle.
- **Counter and sticky priority:** force link_drop_cnt to 16'hFFFF, then another drop -> count stays FFFF. stat_clr in the same cycle as a drop -> count=1. stat_clr with local status high -> sticky bit0 stays 1.
- **Reset mid-drain:** reset_xgmii_rx_n low during ST_DRAIN -> all outputs at reset values asynchronously, and no rx_abort pulse.
